// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, exponent limits and the bit
// layout of the unrounded mantissa handed over by the multiplier.
package fpu_pkg;

    typedef enum logic [1:0] {
        RM_NEAREST = 2'b00,
        RM_ZERO    = 2'b01,
        RM_POS_INF = 2'b10,
        RM_NEG_INF = 2'b11
    } rmode_e;

    localparam int          LATENCY    = 3;
    localparam logic [12:0] EXP_MAX    = 13'd2047;
    localparam int          EXP_BIAS   = 1023;

    localparam int HIDDEN_BIT = 54;
    localparam int GUARD_BIT  = 1;
    localparam int STICKY_BIT = 0;

endpackage

// File: rtl/fpu_round_incr.sv
// Rounding-increment decision: looks at the lsb, guard and sticky bits of an
// unrounded mantissa and decides whether one ulp must be added.
module fpu_round_incr
    import fpu_pkg::*;
(
    input  logic [1:0] rmode,
    input  logic       sign,
    input  logic [2:0] round_bits,
    output logic       inc
);

    logic lsb;
    logic guard;
    logic sticky;

    assign lsb    = round_bits[2];
    assign guard  = round_bits[GUARD_BIT];
    assign sticky = round_bits[STICKY_BIT];

    // Pick the increment for the active rounding mode.
    always_comb begin
        inc = 1'b0;
        case (rmode)
            RM_NEAREST: inc = guard & (sticky | lsb);
            RM_ZERO:    inc = 1'b0;
            RM_POS_INF: inc = ~sign & (guard | sticky);
            RM_NEG_INF: inc = sign & (guard | sticky);
            default:    inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpu_round_pack.sv
// Final stage of the FP multiplier: rounds the unrounded result, handles the
// rounding carry-out, denormal promotion and overflow saturation, then packs
// an IEEE-754 double with its exception flags. Three register stages.
module fpu_round_pack
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        in_valid,
    input  logic        sign,
    input  logic [55:0] mantissa_in,
    input  logic [11:0] exponent_in,
    input  logic [1:0]  rmode,
    output logic        out_valid,
    output logic [63:0] out,
    output logic        inexact,
    output logic        overflow,
    output logic        underflow
);

    logic        s1_valid;
    logic        s1_sign;
    logic [55:0] s1_m;
    logic [11:0] s1_exp;
    logic [1:0]  s1_rmode;

    logic        inc;
    logic        inexact_pre;
    logic [53:0] sum_hi;
    logic [52:0] mant_c;
    logic [12:0] exp_c;

    logic        s2_valid;
    logic        s2_sign;
    logic [1:0]  s2_rmode;
    logic [52:0] s2_mant;
    logic [12:0] s2_exp;
    logic        s2_inexact;

    logic        ovf_c;
    logic        to_inf;
    logic [63:0] result_c;

    fpu_round_incr u_round_incr (
        .rmode      (s1_rmode),
        .sign       (s1_sign),
        .round_bits (s1_m[2:0]),
        .inc        (inc)
    );

    assign inexact_pre = s1_m[GUARD_BIT] | s1_m[STICKY_BIT];

    // Stage 1: capture the raw multiplier result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_m     <= '0;
            s1_exp   <= '0;
            s1_rmode <= '0;
        end else if (enable) begin
            s1_valid <= in_valid;
            s1_sign  <= sign;
            s1_m     <= mantissa_in;
            s1_exp   <= exponent_in;
            s1_rmode <= rmode;
        end
    end

    // Add the increment above the guard/sticky bits, renormalise on carry-out
    // and promote a denormal that rounded up into the normal range.
    always_comb begin
        sum_hi = s1_m[55:2] + {53'd0, inc};
        mant_c = sum_hi[52:0];
        exp_c  = {1'b0, s1_exp};
        if (sum_hi[53]) begin
            mant_c = sum_hi[53:1];
            exp_c  = {1'b0, s1_exp} + 13'd1;
        end else if (s1_exp == 12'd0 && sum_hi[HIDDEN_BIT-2]) begin
            exp_c  = 13'd1;
        end
    end

    // Stage 2: hold the rounded, normalised mantissa and widened exponent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_rmode   <= '0;
            s2_mant    <= '0;
            s2_exp     <= '0;
            s2_inexact <= 1'b0;
        end else if (enable) begin
            s2_valid   <= s1_valid;
            s2_sign    <= s1_sign;
            s2_rmode   <= s1_rmode;
            s2_mant    <= mant_c;
            s2_exp     <= exp_c;
            s2_inexact <= inexact_pre;
        end
    end

    // Saturate on overflow (infinity or max finite depending on direction),
    // otherwise pack, flushing an all-zero mantissa to a signed zero.
    always_comb begin
        ovf_c  = (s2_exp >= EXP_MAX);
        to_inf = (s2_rmode == RM_NEAREST)
               | ((s2_rmode == RM_POS_INF) & ~s2_sign)
               | ((s2_rmode == RM_NEG_INF) & s2_sign);
        if (ovf_c) begin
            if (to_inf) begin
                result_c = {s2_sign, EXP_MAX[10:0], 52'd0};
            end else begin
                result_c = {s2_sign, EXP_MAX[10:0] - 11'd1, {52{1'b1}}};
            end
        end else if (s2_mant == 53'd0) begin
            result_c = {s2_sign, 11'd0, s2_mant[51:0]};
        end else begin
            result_c = {s2_sign, s2_exp[10:0], s2_mant[51:0]};
        end
    end

    // Stage 3: output registers; flags are only raised alongside a valid beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            inexact   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (enable) begin
            out_valid <= s2_valid;
            out       <= result_c;
            inexact   <= s2_valid & (s2_inexact | ovf_c);
            overflow  <= s2_valid & ovf_c;
            underflow <= s2_valid & (s2_exp == 13'd0) & s2_inexact;
        end
    end

endmodule

// File: doc/fpu_round_pack.md
Name: fpu_round_pack

Overview:
- Consumer end of the FP multiplier result interface.
- Takes the unrounded sign, 56-bit mantissa and 12-bit biased exponent from the multiplier, and applies IEEE-754 rounding in one of four modes.
- Handles round carry-out, overflow saturation and denormal-to-normal promotion.
- Packs the final 64-bit double and raises exception flags.
- Sits directly behind fpu_mul in the FPU datapath.

Parameters:
- LATENCY, 3, fixed pipeline depth from in_valid to out_valid; informational, not overridable.
- EXP_MAX, 2047, all-ones biased exponent marking infinity.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- enable  input  1  global advance; 0 holds every pipeline register
- in_valid  input  1  input beat valid
- sign  input  1  result sign
- mantissa_in  input  56  [55]=0 headroom, [54]=hidden bit, [53:2]=fraction, [1]=guard, [0]=sticky
- exponent_in  input  12  biased exponent; 0 means denormal/underflowed
- rmode  input  2  00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
- out_valid  output  1  result valid
- out  output  64  packed double {sign, exp[10:0], frac[51:0]}
- inexact  output  1  guard or sticky set, or overflow occurred
- overflow  output  1  rounded exponent >= EXP_MAX
- underflow  output  1  result exponent 0 and inexact

Behaviour:
- Reset:
  - rst_n low at a rising edge clears all stage registers and valid bits.
  - out, out_valid and all flags are 0 from the next cycle.
  - Reset mid-operation discards in-flight beats. No result for them ever appears.
- Pipeline:
  - Three register stages; each advances only when enable=1.
  - enable=0 freezes data and valid bits, including the output registers.
  - A new beat may be accepted every enabled cycle; there is no backpressure.
  - When in_valid=0, a bubble propagates with out_valid=0. Data registers may update freely.
- Stage 1: register the inputs, then compute the increment. With lsb=m[2], g=m[1], s=m[0]:
  - RNE: inc = g & (s | lsb).
  - RZ: inc = 0.
  - RUP: inc = ~sign & (g | s).
  - RDN: inc = sign & (g | s).
  - Also register inexact_pre = g | s.
- Stage 2: sum = m + (inc << 2), 56-bit.
  - If sum[55]=1: shift sum right 1 and set exp = exponent_in + 1. Use a 13-bit internal exponent; no wrap.
  - Else if exponent_in = 0 and sum[54] = 1: exp = 1 (denormal promoted to normal).
  - Else exp = exponent_in.
- Stage 3, overflow when exp >= EXP_MAX:
  - Result is infinity when rmode=RNE, when rmode=RUP with sign=0, or when rmode=RDN with sign=1: exponent 7FF, fraction 0.
  - Otherwise result is max finite: exponent 7FE, fraction all ones.
  - overflow=1 and inexact=1.
- Stage 3, normal path: out = {sign, exp[10:0], sum[53:2]}.
  - If sum[54:2] is all zero: exponent field forced to 0, giving signed zero.
  - underflow = (exp==0) & inexact_pre.
  - inexact = inexact_pre | overflow.
- Flags are valid only when out_valid=1. They are 0 whenever out_valid=0.

Decomposition:
- Shared package fpu_pkg:
  - rmode constants RM_NEAREST, RM_ZERO, RM_POS_INF, RM_NEG_INF.
  - EXP_MAX, EXP_BIAS=1023.
  - Mantissa bit-position constants HIDDEN_BIT=54, GUARD_BIT=1, STICKY_BIT=0.
- One natural sub-module: fpu_round_incr. Combinational: rmode, sign and m[2:0] produce inc. It is reused by a future divider rounding stage.

Test Plan:
- Exact 1.0: exponent_in=1023, mantissa_in=56'h40_0000_0000_0000, RNE, in_valid pulsed -> out_valid exactly 3 enabled cycles later, out=64'h3FF0_0000_0000_0000, all flags 0.
- Tie-to-even: exp 1023, m=56'h40_0000_0000_0002 (g=1, lsb=0) -> out=64'h3FF0_0000_0000_0000, inexact=1; m=56'h40_0000_0000_0006 -> out=64'h3FF0_0000_0000_0002.
- Carry-out: exp 1023, m=56'h7F_FFFF_FFFF_FFFE, RNE -> out=64'h4000_0000_0000_0000, inexact=1, overflow=0.
- Overflow saturation with exp 2046, m=56'h7F_FFFF_FFFF_FFFE:
  - sign=0, RNE -> 64'h7FF0_0000_0000_0000, overflow=1, inexact=1.
  - sign=0, RZ -> 64'h7FEF_FFFF_FFFF_FFFF.
  - sign=1, RUP -> 64'hFFEF_FFFF_FFFF_FFFF.
- Directed rounding, exp 1023, m=56'h40_0000_0000_0001 (sticky only):
  - sign=1, RDN -> 64'hBFF0_0000_0000_0001.
  - sign=1, RUP -> 64'hBFF0_0000_0000_0000.
  - Both cases inexact=1.
- Control:
  - Drop enable for 2 cycles with 3 beats in flight -> outputs frozen, no beat lost or duplicated.
  - Drive rst_n=0 for one cycle mid-stream -> out_valid=0 and out=0 next cycle, and none of the in-flight beats emerge.
  - Denormal promotion: exp 0, m=56'h3F_FFFF_FFFF_FFFE, RNE -> out=64'h0010_0000_0000_0000, underflow=0, inexact=1.
